// File: rtl/lfsr_checker.sv
// BIST receive checker: locks a local Fibonacci LFSR onto the serial stream, then flags and counts mismatches.
// Latency: all outputs registered, one cycle after the valid bit. Backpressure: none, accepts one bit per clock.
module lfsr_checker #(
    parameter int N           = 4,
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_counts,
    output logic             locked,
    output logic             bit_error,
    output logic             seq_done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);
    localparam int PERIOD = (1 << N) - 1;

    // Tap masks match the generator so both sides walk the same maximal-length sequence.
    localparam logic [7:0] TAPS = (N == 2) ? 8'b0000_0011 :
                                  (N == 3) ? 8'b0000_0110 :
                                  (N == 4) ? 8'b0000_1100 :
                                  (N == 5) ? 8'b0001_0100 :
                                  (N == 6) ? 8'b0011_0000 :
                                  (N == 7) ? 8'b0110_0000 :
                                             8'b1011_1000;

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        r_q, r_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [N-1:0]        period_q, period_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [CNT_W-1:0]    err_d, bcnt_d;
    logic                bit_error_d, seq_done_d;

    logic [N-1:0]        hunt_r;
    logic                pred;
    logic                mismatch;
    logic                fill_full;
    logic                loss;
    logic                wrap;

    assign hunt_r    = {r_q[N-2:0], bit_in};
    assign pred      = ^(r_q & TAPS[N-1:0]);
    assign mismatch  = (bit_in != pred);
    assign fill_full = (fill_q == FILL_W'(N - 1));
    assign loss      = mismatch && (miss_q == MISS_W'(LOSS_THRESH - 1));
    assign wrap      = (period_q == N'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_valid) begin
            case (state_q)
                ST_HUNT:   if (fill_full && (hunt_r != '0)) state_d = ST_LOCKED;
                ST_LOCKED: if (loss) state_d = ST_HUNT;
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    assign locked = (state_q == ST_LOCKED);

    always_comb begin
        r_d         = r_q;
        fill_d      = fill_q;
        period_d    = period_q;
        miss_d      = miss_q;
        err_d       = err_count;
        bcnt_d      = bit_count;
        bit_error_d = 1'b0;
        seq_done_d  = 1'b0;
        if (bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    r_d = hunt_r;
                    if (fill_full) begin
                        fill_d = '0;
                        if (hunt_r != '0) begin
                            err_d    = '0;
                            bcnt_d   = '0;
                            period_d = '0;
                            miss_d   = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Only the prediction is shifted in, so a corrupted bit cannot poison later checks.
                    r_d = {r_q[N-2:0], pred};
                    if (mismatch) begin
                        bit_error_d = 1'b1;
                        miss_d      = miss_q + 1'b1;
                        if (err_count != {CNT_W{1'b1}}) err_d = err_count + 1'b1;
                    end else begin
                        miss_d = '0;
                    end
                    if (bit_count != {CNT_W{1'b1}}) bcnt_d = bit_count + 1'b1;
                    if (wrap) begin
                        period_d   = '0;
                        seq_done_d = 1'b1;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                    if (loss) fill_d = '0;
                end
                default: ;
            endcase
        end
        if (clear_counts) begin
            err_d  = '0;
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= '0;
            fill_q    <= '0;
            period_q  <= '0;
            miss_q    <= '0;
            err_count <= '0;
            bit_count <= '0;
            bit_error <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            r_q       <= r_d;
            fill_q    <= fill_d;
            period_q  <= period_d;
            miss_q    <= miss_d;
            err_count <= err_d;
            bit_count <= bcnt_d;
            bit_error <= bit_error_d;
            seq_done  <= seq_done_d;
        end
    end

endmodule
